// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit with private HI/LO registers.
// Shift-add multiply and restoring divide, one iteration per clock, start/finish handshake.
module muldiv_unit #(
    parameter int ITERS = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic        [4:0]  aluop,
    input  logic signed [31:0] aluA,
    input  logic signed [31:0] aluB,
    output logic        [31:0] hiOut,
    output logic        [31:0] loOut,
    output logic               finish
);
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);
    localparam logic [4:0] OP_MTHI = 5'b01001;
    localparam logic [4:0] OP_MTLO = 5'b01011;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      acc;
    logic [31:0]      mcand;
    logic             op_div;
    logic             neg_res;
    logic             neg_rem;

    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] x, input logic en);
        return en ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x, input logic en);
        return en ? (~x + 64'd1) : x;
    endfunction

    logic        is_mdu;
    logic        op_signed;
    logic        div_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign is_mdu    = (aluop[4:2] == 3'b011);
    assign op_signed = ~aluop[0];
    assign div_zero  = aluop[1] && (aluB == '0);
    assign mag_a     = magnitude(aluA, op_signed);
    assign mag_b     = magnitude(aluB, op_signed);

    // Multiply step: the add carry lands in bit 63 after the right shift.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Divide step: the partial remainder is 33 bits wide once shifted, so the trial subtract is too.
    logic [32:0] div_diff;
    logic [63:0] div_next;
    assign div_diff = acc[63:31] - {1'b0, mcand};
    assign div_next = div_diff[32] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};

    logic [63:0] acc_next;
    logic [63:0] prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        acc_next = op_div ? div_next : mul_next;
        prod     = neg64(mul_next, neg_res);
        res_hi   = prod[63:32];
        res_lo   = prod[31:0];
        if (op_div) begin
            res_hi = neg32(div_next[63:32], neg_rem);
            res_lo = neg32(div_next[31:0], neg_res);
        end
    end

    always_ff @(posedge CLK) begin
        if (state == IDLE && start && is_mdu) begin
            op_div  <= aluop[1];
            neg_res <= op_signed & (aluA[31] ^ aluB[31]);
            neg_rem <= op_signed & aluA[31];
            if (aluop[1]) begin
                acc   <= {32'd0, mag_a};
                mcand <= mag_b;
            end else begin
                acc   <= {32'd0, mag_b};
                mcand <= mag_a;
            end
        end else if (state == CALC) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            cnt    <= '0;
            hiOut  <= '0;
            loOut  <= '0;
            finish <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_mdu) begin
                        cnt <= '0;
                        if (div_zero) begin
                            hiOut  <= aluA;
                            loOut  <= '1;
                            finish <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end else if (!start && aluop == OP_MTHI) begin
                        hiOut <= aluA;
                    end else if (!start && aluop == OP_MTLO) begin
                        loOut <= aluA;
                    end
                end
                CALC: begin
                    if (!start) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            hiOut  <= res_hi;
                            loOut  <= res_lo;
                            finish <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with its own HI/LO register pair, responding to the ALU's level-sensitive `start`/`finish` handshake. The ALU raises `start` on a MULT/MULTU/DIV/DIVU opcode and holds it (stalling the pipeline) until `finish` is seen. The unit computes the 64-bit result in 32 iterations, writes HI/LO, and pulses `finish`. It also serves MTHI/MTLO writes, and drives `hiOut`/`loOut` for MFHI/MFLO.

## Interface
- `ITERS`, 32, iteration count for multiply and divide; operands are fixed at 32 bits.
- `CLK`  in  1  rising-edge clock
- `RST_N`  in  1  asynchronous active-low reset
- `start`  in  1  operation request; level, held high by ALU until `finish`
- `aluop`  in  5  01100 MULT, 01101 MULTU, 01110 DIV, 01111 DIVU, 01001 MTHI, 01011 MTLO
- `aluA`  in  32  signed operand A: multiplicand / dividend / MTHI-MTLO data
- `aluB`  in  32  signed operand B: multiplier / divisor
- `hiOut`  out  32  HI register; reset 0
- `loOut`  out  32  LO register; reset 0
- `finish`  out  1  completion pulse, one cycle; reset 0

## Operation
- States: IDLE, CALC, DONE.
  - `finish` = (state == DONE), a Moore output.
- IDLE, `start`=1, `aluop` ∈ {01100..01111}:
  - Latch the opcode.
  - Latch signedness: 01100 and 01110 are signed.
  - Latch the operand magnitudes and result-sign flags.
  - Clear the iteration counter, then go to CALC.
- IDLE, `start`=1, other `aluop`: ignored, stay IDLE.
- IDLE, `start`=0, `aluop`=01001: HI <= `aluA` on the edge.
- IDLE, `start`=0, `aluop`=01011: LO <= `aluA` on the edge.
- MTHI/MTLO are ignored outside IDLE.
- Signed magnitudes: two's-complement negate when the sign bit is set, treating the result as unsigned 32-bit, so 0x80000000 maps to 2^31.
  - Unsigned ops use the operands as-is; sign flags are 0.
- Multiply (shift-add):
  - 65-bit accumulator {carry, P_hi, multiplier}.
  - Each CALC cycle: if LSB=1, add the multiplicand to {carry, P_hi}; then shift the accumulator right by 1.
  - Final 64-bit product is negated if the operand signs differ. HI = upper 32 bits, LO = lower 32 bits.
- Divide (restoring):
  - 64-bit {R, Q}, R=0 and Q=|dividend| initially.
  - Each cycle: shift left 1, trial-subtract |divisor| from R. If non-negative, keep the difference and set Q[0]=1.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign. LO = quotient, HI = remainder.
  - -2^31 / -1 gives LO=0x80000000, HI=0 with no special casing.
- Divide by zero (`aluB`=0, DIV or DIVU):
  - Detected in IDLE; go straight to DONE.
  - HI <= `aluA`, LO <= 0xFFFFFFFF. No iterations are run.
- CALC exit: after iteration `ITERS`-1, write the sign-corrected HI/LO on the same edge and go to DONE.
- DONE: always returns to IDLE on the next edge, whatever `start` is.
- Abort: `start`=0 while in CALC (pipeline flush) returns the unit to IDLE on the next edge. HI/LO are unchanged and `finish` is not asserted.
- `aluop`/`aluA`/`aluB` changes during CALC are ignored because operands are latched.

## Timing
- Cycle 0: IDLE with `start`=1 is sampled.
- Cycles 1..32: CALC.
- Cycle 33: DONE, `finish`=1, HI/LO already hold the new result.
- The ALU sees 33 stall cycles; `start` falls combinationally in cycle 33.
- Divide by zero: `finish`=1 in cycle 1.
- Back-to-back operations: a new `start` is accepted in the first IDLE cycle after DONE, i.e. cycle 34.
- MTHI/MTLO: visible on `hiOut`/`loOut` the cycle after the edge.
- `RST_N` low at any time, including mid-CALC:
  - Immediately: state IDLE, counter 0, HI=LO=0, `finish`=0.
  - Release is synchronised by the flop recovery time only; no operation resumes.

## Test plan
- MULT `aluA`=-3, `aluB`=7, start held until finish:
  - `finish` high only in cycle 33.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - HI=0xFFFFFFFE, LO=0x00000001.
  - Then MULT on the same operands gives HI=0, LO=1.
- DIV -7/2:
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF:
  - LO=0x80000000, HI=0.
- DIVU 7/0:
  - `finish` in cycle 1, HI=7, LO=0xFFFFFFFF.
- Abort and reset:
  - Preload MTHI 0x1234 / MTLO 0x5678. Start MULT 5×5 and drop `start` in cycle 10: no `finish`, HI/LO stay 0x1234/0x5678.
  - Restart MULT 5×5 and assert `RST_N`=0 in cycle 20: HI=LO=0 and `finish`=0 immediately, state IDLE.
